// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
// Two-master round-robin front-end for a single-port synchronous memory
// with a registered read port. A request is sampled in IDLE, the winning
// master's operation is latched, the memory is driven for exactly one ACCESS
// cycle, read data is captured one cycle later, and a one-cycle done pulse
// is returned to the owner.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   req0/wr0/addr0/wdata0 master 0 request, op (1 = write), address, data
//   req1/wr1/addr1/wdata1 master 1 request, op, address, data
//   gnt0/gnt1             owner of the bus while a transaction is in flight
//   done0/done1           one-cycle completion pulse to the owner
//   rdata                 last read data, valid with the done of a read
//   busy                  transaction in progress
//   m_cen/m_wen/m_addr/m_din  memory port, driven only during ACCESS
//   m_dout                registered memory read data
module mem_bus_arbiter #(
  parameter int AW = 5,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0,
  input  logic          wr0,
  input  logic [AW-1:0] addr0,
  input  logic [DW-1:0] wdata0,
  input  logic          req1,
  input  logic          wr1,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata1,
  output logic          gnt0,
  output logic          gnt1,
  output logic          done0,
  output logic          done1,
  output logic [DW-1:0] rdata,
  output logic          busy,
  output logic          m_cen,
  output logic          m_wen,
  output logic [AW-1:0] m_addr,
  output logic [DW-1:0] m_din,
  input  logic [DW-1:0] m_dout
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] ACCESS    = 2'd1;
  localparam logic [1:0] READ_WAIT = 2'd2;
  localparam logic [1:0] RESP      = 2'd3;

  logic [1:0]    state;
  logic          owner;
  logic          last_owner;
  logic          lat_wr;
  logic [AW-1:0] lat_addr;
  logic [DW-1:0] lat_wdata;
  logic          winner;

  // Round-robin pick: a lone requester always wins; on a tie the master
  // that did not win last time gets the bus.
  always_comb begin
    winner = req1;
    if (req0 && req1) begin
      winner = ~last_owner;
    end
  end

  // Transaction sequencer. The request is latched once in IDLE so later
  // input changes cannot disturb the transaction in flight. rdata only
  // moves at the end of READ_WAIT, when the memory's registered dout holds
  // the word addressed during ACCESS.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_owner <= 1'b1;
      lat_wr     <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      rdata      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            owner      <= winner;
            last_owner <= winner;
            lat_wr     <= winner ? wr1 : wr0;
            lat_addr   <= winner ? addr1 : addr0;
            lat_wdata  <= winner ? wdata1 : wdata0;
            state      <= ACCESS;
          end
        end
        ACCESS: begin
          state <= lat_wr ? RESP : READ_WAIT;
        end
        READ_WAIT: begin
          rdata <= m_dout;
          state <= RESP;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // All outputs decode from registered state and latched fields only, so
  // nothing on the request side reaches an output combinationally.
  assign busy   = (state != IDLE);
  assign gnt0   = busy && !owner;
  assign gnt1   = busy && owner;
  assign done0  = (state == RESP) && !owner;
  assign done1  = (state == RESP) && owner;
  assign m_cen  = (state == ACCESS);
  assign m_wen  = m_cen && lat_wr;
  assign m_addr = m_cen ? lat_addr : '0;
  assign m_din  = m_wen ? lat_wdata : '0;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter
// Self-checking bench for mem_bus_arbiter. A behavioural 32x32 memory with a
// registered read port sits on the m_* port. Expected values come from a
// transaction-level reference: an array of memory contents, the last read
// value, the round-robin rule and fixed write/read latencies.
module tb_mem_bus_arbiter;

  logic        clk;
  logic        reset;
  logic        req0, wr0, req1, wr1;
  logic [4:0]  addr0, addr1;
  logic [31:0] wdata0, wdata1;
  logic        gnt0, gnt1, done0, done1, busy;
  logic [31:0] rdata;
  logic        m_cen, m_wen;
  logic [4:0]  m_addr;
  logic [31:0] m_din;
  logic [31:0] m_dout = '0;
  logic [31:0] mem [32] = '{default: '0};

  typedef struct {
    bit          m;
    logic [31:0] data;
    int          cyc;
  } done_t;

  typedef struct {
    logic        wen;
    logic [4:0]  addr;
    logic [31:0] din;
    int          cyc;
  } acc_t;

  done_t       done_q[$];
  acc_t        acc_q[$];
  int          cyc;
  int          gnt0_cnt, gnt1_cnt;
  bit          both_gnt;
  int          n_checks;
  int          n_fail;

  logic [31:0] ref_mem [32] = '{default: '0};
  logic [31:0] last_rd;
  bit          model_last;

  mem_bus_arbiter #(.AW(5), .DW(32)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .wr0(wr0), .addr0(addr0), .wdata0(wdata0),
    .req1(req1), .wr1(wr1), .addr1(addr1), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .rdata(rdata), .busy(busy),
    .m_cen(m_cen), .m_wen(m_wen), .m_addr(m_addr), .m_din(m_din),
    .m_dout(m_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: writes commit on the edge ending ACCESS, read data
  // appears one cycle later and is zero whenever no read was issued.
  always @(posedge clk) begin
    if (m_cen && m_wen) mem[m_addr] <= m_din;
    m_dout <= (m_cen && !m_wen) ? mem[m_addr] : 32'h0;
  end

  // Advance to the next falling edge and log what the DUT shows this cycle.
  task automatic step();
    @(negedge clk);
    cyc++;
    if (gnt0 && gnt1) both_gnt = 1'b1;
    if (gnt0) gnt0_cnt++;
    if (gnt1) gnt1_cnt++;
    if (done0) done_q.push_back('{1'b0, rdata, cyc});
    if (done1) done_q.push_back('{1'b1, rdata, cyc});
    if (m_cen) acc_q.push_back('{m_wen, m_addr, m_din, cyc});
  endtask

  task automatic drive(input bit m, input bit r, input bit w,
                       input logic [4:0] a, input logic [31:0] d);
    if (m) begin
      req1 = r; wr1 = w; addr1 = a; wdata1 = d;
    end else begin
      req0 = r; wr0 = w; addr0 = a; wdata0 = d;
    end
  endtask

  task automatic clear_log();
    done_q.delete();
    acc_q.delete();
    gnt0_cnt = 0;
    gnt1_cnt = 0;
    both_gnt = 1'b0;
  endtask

  // Reference model: one completed transaction in service order.
  task automatic model_txn(input bit m, input bit w, input logic [4:0] a,
                           input logic [31:0] d, output logic [31:0] exp_rd);
    if (w) ref_mem[a] = d;
    else last_rd = ref_mem[a];
    exp_rd = last_rd;
    model_last = m;
  endtask

  task automatic model_reset();
    model_last = 1'b1;
    last_rd = '0;
  endtask

  // Run one transaction for a single master; lat counts cycles from the
  // IDLE sampling cycle to the done cycle.
  task automatic run_txn(input bit m, input bit w, input logic [4:0] a,
                         input logic [31:0] d, output int lat,
                         output logic [31:0] rd, output bit tmo);
    int start;
    bit got;
    step();
    drive(m, 1'b1, w, a, d);
    start = cyc;
    got = 1'b0;
    lat = -1;
    rd = 'x;
    for (int i = 0; i < 10 && !got; i++) begin
      step();
      if (m ? done1 : done0) begin
        got = 1'b1;
        lat = cyc - start;
        rd = rdata;
      end
    end
    drive(m, 1'b0, 1'b0, 5'd0, 32'h0);
    tmo = !got;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
    step();
    step();
    n_checks++;
    if ({gnt0, gnt1, done0, done1, busy, m_cen, m_wen} !== 7'b0) begin
      n_fail++;
      $display("[TB] FAIL reset_ctrl: got %b expected 0000000",
               {gnt0, gnt1, done0, done1, busy, m_cen, m_wen});
    end
    n_checks++;
    if ({m_addr, m_din, rdata} !== 69'h0) begin
      n_fail++;
      $display("[TB] FAIL reset_data: got addr %h din %h rdata %h expected 0",
               m_addr, m_din, rdata);
    end
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_write();
    int lat; logic [31:0] rd, exp_rd; bit tmo;
    clear_log();
    run_txn(1'b0, 1'b1, 5'd3, 32'hDEADBEEF, lat, rd, tmo);
    model_txn(1'b0, 1'b1, 5'd3, 32'hDEADBEEF, exp_rd);
    n_checks++;
    if (tmo !== 1'b0) begin n_fail++; $display("[TB] FAIL t1_timeout: got %0b expected 0", tmo); end
    n_checks++;
    if (lat !== 2) begin n_fail++; $display("[TB] FAIL t1_latency: got %0d expected 2", lat); end
    n_checks++;
    if (acc_q.size() !== 1) begin
      n_fail++; $display("[TB] FAIL t1_access_count: got %0d expected 1", acc_q.size());
    end else begin
      n_checks++;
      if ({acc_q[0].wen, acc_q[0].addr, acc_q[0].din} !== {1'b1, 5'd3, 32'hDEADBEEF}) begin
        n_fail++;
        $display("[TB] FAIL t1_access: got wen %b addr %0d din %h expected 1 3 deadbeef",
                 acc_q[0].wen, acc_q[0].addr, acc_q[0].din);
      end
    end
    n_checks++;
    if (gnt0_cnt !== 2 || gnt1_cnt !== 0) begin
      n_fail++; $display("[TB] FAIL t1_gnt_cycles: got %0d/%0d expected 2/0", gnt0_cnt, gnt1_cnt);
    end
  endtask

  task automatic test_read();
    int lat; logic [31:0] rd, exp_rd; bit tmo;
    clear_log();
    run_txn(1'b1, 1'b0, 5'd3, 32'h0, lat, rd, tmo);
    model_txn(1'b1, 1'b0, 5'd3, 32'h0, exp_rd);
    n_checks++;
    if (tmo !== 1'b0 || lat !== 3) begin
      n_fail++; $display("[TB] FAIL t2_latency: got %0d (timeout %0b) expected 3", lat, tmo);
    end
    n_checks++;
    if (rd !== exp_rd) begin n_fail++; $display("[TB] FAIL t2_rdata: got %h expected %h", rd, exp_rd); end
    n_checks++;
    if (gnt1_cnt !== 3 || gnt0_cnt !== 0) begin
      n_fail++; $display("[TB] FAIL t2_gnt_cycles: got %0d/%0d expected 0/3", gnt0_cnt, gnt1_cnt);
    end
    n_checks++;
    if (acc_q.size() !== 1 || acc_q[0].din !== 32'h0 || acc_q[0].wen !== 1'b0) begin
      n_fail++; $display("[TB] FAIL t2_read_access: got %0d accesses expected one read with din 0", acc_q.size());
    end
    for (int i = 0; i < 3; i++) step();
    n_checks++;
    if (rdata !== 32'hDEADBEEF) begin n_fail++; $display("[TB] FAIL t2_rdata_hold: got %h expected deadbeef", rdata); end
  endtask

  task automatic test_round_robin();
    int lat; logic [31:0] rd, exp_rd; bit tmo; bit exp_m;
    run_txn(1'b1, 1'b1, 5'd0, 32'h11, lat, rd, tmo);
    model_txn(1'b1, 1'b1, 5'd0, 32'h11, exp_rd);
    run_txn(1'b1, 1'b1, 5'd1, 32'h22, lat, rd, tmo);
    model_txn(1'b1, 1'b1, 5'd1, 32'h22, exp_rd);
    step();
    clear_log();
    drive(1'b0, 1'b1, 1'b0, 5'd0, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 5'd1, 32'h0);
    for (int i = 0; i < 40 && done_q.size() < 4; i++) step();
    drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
    n_checks++;
    if (done_q.size() !== 4) begin n_fail++; $display("[TB] FAIL t3_done_count: got %0d expected 4", done_q.size()); end
    for (int k = 0; k < done_q.size() && k < 4; k++) begin
      exp_m = !model_last;
      model_txn(exp_m, 1'b0, exp_m ? 5'd1 : 5'd0, 32'h0, exp_rd);
      n_checks++;
      if (done_q[k].m !== exp_m || done_q[k].data !== exp_rd) begin
        n_fail++;
        $display("[TB] FAIL t3_grant_%0d: got master %0d data %h expected master %0d data %h",
                 k, done_q[k].m, done_q[k].data, exp_m, exp_rd);
      end
    end
    n_checks++;
    if (both_gnt !== 1'b0) begin n_fail++; $display("[TB] FAIL t3_gnt_exclusive: got both granted expected never"); end
  endtask

  task automatic test_back_to_back();
    int lat; logic [31:0] rd, exp_rd; bit tmo;
    step();
    clear_log();
    drive(1'b1, 1'b1, 1'b1, 5'd31, 32'hFFFFFFFF);
    for (int i = 0; i < 20 && done_q.size() < 3; i++) step();
    drive(1'b1, 1'b0, 1'b0, 5'd0, 32'h0);
    model_txn(1'b1, 1'b1, 5'd31, 32'hFFFFFFFF, exp_rd);
    n_checks++;
    if (done_q.size() !== 3 || acc_q.size() !== 3) begin
      n_fail++; $display("[TB] FAIL t4_count: got %0d done %0d access expected 3 3", done_q.size(), acc_q.size());
    end
    for (int k = 0; k < acc_q.size(); k++) begin
      n_checks++;
      if ({acc_q[k].wen, acc_q[k].addr, acc_q[k].din} !== {1'b1, 5'd31, 32'hFFFFFFFF}) begin
        n_fail++; $display("[TB] FAIL t4_access_%0d: got addr %0d din %h expected 31 ffffffff", k, acc_q[k].addr, acc_q[k].din);
      end
      if (k > 0) begin
        n_checks++;
        if (acc_q[k].cyc - acc_q[k-1].cyc !== 3) begin
          n_fail++; $display("[TB] FAIL t4_spacing_%0d: got %0d expected 3", k, acc_q[k].cyc - acc_q[k-1].cyc);
        end
      end
    end
    run_txn(1'b0, 1'b0, 5'd31, 32'h0, lat, rd, tmo);
    model_txn(1'b0, 1'b0, 5'd31, 32'h0, exp_rd);
    n_checks++;
    if (rd !== exp_rd) begin n_fail++; $display("[TB] FAIL t4_read31: got %h expected %h", rd, exp_rd); end
    run_txn(1'b0, 1'b0, 5'd0, 32'h0, lat, rd, tmo);
    model_txn(1'b0, 1'b0, 5'd0, 32'h0, exp_rd);
    n_checks++;
    if (rd !== exp_rd) begin n_fail++; $display("[TB] FAIL t4_read0: got %h expected %h", rd, exp_rd); end
  endtask

  task automatic test_reset_mid_read();
    int lat; logic [31:0] rd, exp_rd, val; bit tmo;
    val = $urandom | 32'h1;
    run_txn(1'b1, 1'b1, 5'd5, val, lat, rd, tmo);
    model_txn(1'b1, 1'b1, 5'd5, val, exp_rd);
    step();
    drive(1'b0, 1'b1, 1'b0, 5'd5, 32'h0);
    step();
    step();
    n_checks++;
    if (busy !== 1'b1 || gnt0 !== 1'b1) begin n_fail++; $display("[TB] FAIL t5_in_read_wait: got busy %b gnt0 %b expected 1 1", busy, gnt0); end
    reset = 1'b1;
    clear_log();
    step();
    n_checks++;
    if ({busy, gnt0, done0, rdata} !== 35'h0) begin
      n_fail++; $display("[TB] FAIL t5_after_reset: got busy %b gnt0 %b done0 %b rdata %h expected 0", busy, gnt0, done0, rdata);
    end
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    model_reset();
    step();
    step();
    n_checks++;
    if (done_q.size() !== 0) begin n_fail++; $display("[TB] FAIL t5_no_done: got %0d pulses expected 0", done_q.size()); end
    run_txn(1'b0, 1'b0, 5'd5, 32'h0, lat, rd, tmo);
    model_txn(1'b0, 1'b0, 5'd5, 32'h0, exp_rd);
    n_checks++;
    if (rd !== exp_rd || lat !== 3) begin n_fail++; $display("[TB] FAIL t5_reread: got %h lat %0d expected %h lat 3", rd, lat, exp_rd); end
  endtask

  task automatic test_input_change();
    int lat; logic [31:0] rd, exp_rd; bit tmo;
    step();
    clear_log();
    drive(1'b0, 1'b1, 1'b1, 5'd9, 32'hA5A5_0001);
    step();
    drive(1'b0, 1'b1, 1'b0, 5'd10, 32'h5A5A_0002);
    for (int i = 0; i < 10 && done_q.size() < 1; i++) step();
    drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0);
    model_txn(1'b0, 1'b1, 5'd9, 32'hA5A5_0001, exp_rd);
    n_checks++;
    if (acc_q.size() !== 1 || {acc_q[0].wen, acc_q[0].addr, acc_q[0].din} !== {1'b1, 5'd9, 32'hA5A5_0001}) begin
      n_fail++; $display("[TB] FAIL t6_access: got %0d accesses expected one write of a5a50001 to 9", acc_q.size());
    end
    run_txn(1'b1, 1'b0, 5'd9, 32'h0, lat, rd, tmo);
    model_txn(1'b1, 1'b0, 5'd9, 32'h0, exp_rd);
    n_checks++;
    if (rd !== exp_rd) begin n_fail++; $display("[TB] FAIL t6_readback: got %h expected %h", rd, exp_rd); end
  endtask

  task automatic test_random();
    bit          m_list [2];
    bit          rq_w [2];
    logic [4:0]  rq_a [2];
    logic [31:0] rq_d [2];
    logic [31:0] exp_rd;
    int          pat, n, start;
    bit          mm;
    clear_log();
    for (int it = 0; it < 40; it++) begin
      step();
      pat = $urandom_range(1, 3);
      for (int m = 0; m < 2; m++) begin
        rq_w[m] = 1'($urandom_range(0, 1));
        rq_a[m] = 5'($urandom_range(0, 31));
        rq_d[m] = $urandom;
      end
      if (pat == 3) begin
        n = 2; m_list[0] = !model_last; m_list[1] = model_last;
      end else begin
        n = 1; m_list[0] = (pat == 2); m_list[1] = 1'b0;
      end
      done_q.delete();
      acc_q.delete();
      start = cyc;
      if ((pat & 1) != 0) drive(1'b0, 1'b1, rq_w[0], rq_a[0], rq_d[0]);
      if ((pat & 2) != 0) drive(1'b1, 1'b1, rq_w[1], rq_a[1], rq_d[1]);
      for (int i = 0; i < 20 && done_q.size() < n; i++) begin
        step();
        if (done0) req0 = 1'b0;
        if (done1) req1 = 1'b0;
      end
      req0 = 1'b0;
      req1 = 1'b0;
      n_checks++;
      if (done_q.size() !== n) begin n_fail++; $display("[TB] FAIL rnd%0d_count: got %0d expected %0d", it, done_q.size(), n); end
      for (int k = 0; k < n && k < done_q.size(); k++) begin
        mm = m_list[k];
        model_txn(mm, rq_w[mm], rq_a[mm], rq_d[mm], exp_rd);
        n_checks++;
        if (done_q[k].m !== mm || done_q[k].data !== exp_rd) begin
          n_fail++;
          $display("[TB] FAIL rnd%0d_done%0d: got master %0d rdata %h expected master %0d rdata %h",
                   it, k, done_q[k].m, done_q[k].data, mm, exp_rd);
        end
        if (k < acc_q.size()) begin
          n_checks++;
          if ({acc_q[k].wen, acc_q[k].addr, acc_q[k].din} !== {rq_w[mm], rq_a[mm], rq_w[mm] ? rq_d[mm] : 32'h0}) begin
            n_fail++;
            $display("[TB] FAIL rnd%0d_access%0d: got wen %b addr %0d din %h expected wen %b addr %0d",
                     it, k, acc_q[k].wen, acc_q[k].addr, acc_q[k].din, rq_w[mm], rq_a[mm]);
          end
        end
      end
      if (done_q.size() > 0) begin
        n_checks++;
        if (done_q[0].cyc - start !== (rq_w[m_list[0]] ? 2 : 3)) begin
          n_fail++; $display("[TB] FAIL rnd%0d_latency: got %0d expected %0d", it, done_q[0].cyc - start, rq_w[m_list[0]] ? 2 : 3);
        end
      end
    end
    n_checks++;
    if (both_gnt !== 1'b0) begin n_fail++; $display("[TB] FAIL rnd_gnt_exclusive: got both granted expected never"); end
  endtask

  initial begin
    cyc = 0;
    n_checks = 0;
    n_fail = 0;
    clear_log();
    model_reset();
    $display("[TB] starting mem_bus_arbiter bench");
    test_reset();
    test_write();
    test_read();
    test_round_robin();
    test_back_to_back();
    test_reset_mid_read();
    test_input_change();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Two-master bus front-end that sits directly upstream of the 32x32 single-port synchronous memory.
- Arbitrates read/write requests from master 0 and master 1 round-robin and drives the memory port (cen, wen, addr, din).
- Captures the memory's registered dout and returns it to the granted master with a one-cycle done pulse.

Parameters:
AW, 5, address width (memory depth 2^AW words)
DW, 32, data width

Ports:
clk  input  1  clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
req0  input  1  master 0 request, held until done0
wr0  input  1  master 0 op: 1 = write, 0 = read
addr0  input  AW  master 0 address
wdata0  input  DW  master 0 write data
req1  input  1  master 1 request
wr1  input  1  master 1 op
addr1  input  AW  master 1 address
wdata1  input  DW  master 1 write data
gnt0  output  1  master 0 owns bus
gnt1  output  1  master 1 owns bus
done0  output  1  one-cycle completion pulse, master 0
done1  output  1  one-cycle completion pulse, master 1
rdata  output  DW  read data, valid with done pulse of a read
busy  output  1  transaction in progress (state != IDLE)
m_cen  output  1  memory chip enable
m_wen  output  1  memory write enable
m_addr  output  AW  memory address
m_din  output  DW  memory write data
m_dout  input  DW  memory read data (registered in memory, 1-cycle latency, 0 when not reading)

Behaviour:
- Reset, sampled on the clk edge:
  - state=IDLE; latched owner/wr/addr/wdata = 0.
  - last_owner=1, so master 0 wins the first tie.
  - rdata=0.
  - All outputs 0: gnt*, done*, busy, m_cen, m_wen, m_addr, m_din.
- FSM states: IDLE, ACCESS, READ_WAIT, RESP.
- IDLE:
  - m_cen=0.
  - If any req, the winner's wr/addr/wdata are latched with owner=winner; next state ACCESS.
  - Only one req: that master wins.
  - Both req: the master != last_owner wins.
  - last_owner is updated to the winner at this edge.
- ACCESS (exactly 1 cycle):
  - m_cen=1, m_wen=latched wr, m_addr=latched addr.
  - m_din = latched wdata on a write, 0 on a read.
  - Memory samples at the end of this cycle.
  - Next state: write -> RESP; read -> READ_WAIT.
- READ_WAIT (1 cycle):
  - m_cen=0.
  - m_dout is valid here; rdata <= m_dout at the end of the cycle.
  - Next state RESP.
- RESP (1 cycle):
  - done[owner]=1; m_cen=0; next state IDLE.
  - The master must drop or change req in the cycle after done. A req still high in IDLE is a new request.
- gnt[owner]=1 throughout ACCESS, READ_WAIT and RESP; both gnt are 0 in IDLE. gnt0 and gnt1 are never both 1.
- busy=1 in every state except IDLE.
- Latency from the first IDLE cycle with req high to the done pulse:
  - write: 2 cycles after the sampling edge (done in the 3rd cycle).
  - read: 3 cycles after the sampling edge (done in the 4th cycle).
- Minimum spacing between transactions: 1 IDLE cycle.
- rdata holds its last read value across writes and idle time. It is updated only by a read, at the end of READ_WAIT.
- Inputs changing after the IDLE sampling edge have no effect on the transaction in flight.
- All control outputs (m_*, gnt*, done*, busy) are decoded from the registered state and latched fields only. No combinational path from req*/addr*/wdata* to any output.
- Address is AW bits wide with no range check. Address 31 is a normal location.
- Reset mid-transaction: next state IDLE, with no done pulse and rdata cleared to 0. A memory write whose ACCESS edge already occurred stays committed.
- Reset has priority over every other transition.

Test Plan:
1. Reset, then req0 with wr0=1, addr0=3, wdata0=32'hDEADBEEF held until done0.
   -> m_cen=m_wen=1 with m_addr=3 for exactly 1 cycle; gnt0=1 for 2 cycles; done0 in the 3rd cycle.
2. After test 1, req1 with wr1=0, addr1=3.
   -> gnt1 for 3 cycles; done1 in the 4th cycle with rdata=32'hDEADBEEF; rdata holds 32'hDEADBEEF afterwards.
3. req0 and req1 both held high with reads to addr 0 and addr 1 (preloaded with 32'h11 and 32'h22).
   -> grant order 0,1,0,1; each done pulse carries that master's data; gnt0 and gnt1 never both 1.
4. Only req1 held continuously, writing addr 31 with 32'hFFFFFFFF.
   -> repeated transactions separated by 1 IDLE cycle, m_addr=31.
   -> A subsequent read of addr 31 returns 32'hFFFFFFFF; addr 0 is unaffected.
5. Read of addr 5 with reset asserted during READ_WAIT.
   -> next cycle: state IDLE, busy=0, no done, rdata=0.
   -> A following read of addr 5 returns the stored value.
6. Write request with wdata changed after the sampling edge.
   -> the memory receives the originally sampled value, confirmed by read-back.
